// File: rtl/button_event_classifier_if.sv
// Purpose: bundles the classifier's gesture inputs and its event/busy outputs.
// Latency: none, this is wiring only.
// Backpressure: none; the events are fire-and-forget pulses.
interface button_event_classifier_if;
  logic press;
  logic level;
  logic short_press;
  logic long_press;
  logic double_press;
  logic busy;

  // The upstream side drives the debounced inputs and observes the events.
  modport master (
    output press,
    output level,
    input  short_press,
    input  long_press,
    input  double_press,
    input  busy
  );

  // The classifier consumes the inputs and produces the events.
  modport slave (
    input  press,
    input  level,
    output short_press,
    output long_press,
    output double_press,
    output busy
  );
endinterface

// File: rtl/button_event_classifier.sv
// Purpose: classifies each button gesture as short, long or double press.
// Latency: long after LONG_CYC held cycles; short DBL_WIN cycles after release; double on 2nd release.
// Backpressure: none; each event is a single registered pulse, at most one per cycle.
module button_event_classifier #(
  parameter int unsigned     CW       = 8,
  parameter logic [CW-1:0]   LONG_CYC = 8'd50,
  parameter logic [CW-1:0]   DBL_WIN  = 8'd30
) (
  input  logic                        clk,
  input  logic                        rst_n,
  button_event_classifier_if.slave    btn
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HELD     = 3'd1,
    LONGHOLD = 3'd2,
    WAIT2    = 3'd3,
    HELD2    = 3'd4
  } state_t;

  // Terminal counts; the counter never reaches beyond these, so it cannot wrap.
  localparam logic [CW-1:0] LONG_LAST = LONG_CYC - 1'b1;
  localparam logic [CW-1:0] DBL_LAST  = DBL_WIN - 1'b1;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          short_press_q, short_press_d;
  logic          long_press_q, long_press_d;
  logic          double_press_q, double_press_d;

  // Next-state, counter and event decode; events are only ever raised on an exit transition.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    short_press_d  = 1'b0;
    long_press_d   = 1'b0;
    double_press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (btn.press) begin
          state_d = HELD;
          cnt_d   = '0;
        end
      end
      HELD: begin
        // Release wins over the long timeout when both land on the same edge.
        if (!btn.level) begin
          state_d = WAIT2;
          cnt_d   = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d      = LONGHOLD;
          long_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LONGHOLD: begin
        if (!btn.level) begin
          state_d = IDLE;
        end
      end
      WAIT2: begin
        // A second press wins over the window timeout on the same edge.
        if (btn.press) begin
          state_d = HELD2;
        end else if (cnt_q == DBL_LAST) begin
          state_d       = IDLE;
          short_press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD2: begin
        if (!btn.level) begin
          state_d        = IDLE;
          double_press_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and event registers; reset aborts any gesture without an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      short_press_q  <= 1'b0;
      long_press_q   <= 1'b0;
      double_press_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      short_press_q  <= short_press_d;
      long_press_q   <= long_press_d;
      double_press_q <= double_press_d;
    end
  end

  assign btn.short_press  = short_press_q;
  assign btn.long_press   = long_press_q;
  assign btn.double_press = double_press_q;
  assign btn.busy         = (state_q != IDLE);

endmodule

// File: tb/tb_button_event_classifier.sv
// Purpose: scoreboard bench for the button event classifier with LONG_CYC=8, DBL_WIN=6, CW=4.
// Latency: expected events carry the edge number after which they must be seen.
// Backpressure: none; inputs are driven one cycle at a time.
module tb_button_event_classifier;
  localparam int EV_SHORT = 1;
  localparam int EV_LONG  = 2;
  localparam int EV_DBL   = 3;

  logic clk;
  logic rst_n;
  button_event_classifier_if btn_if ();

  button_event_classifier #(
    .CW       (4),
    .LONG_CYC (4'd8),
    .DBL_WIN  (4'd6)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_if.slave)
  );

  int checks_n = 0;
  int errors_n = 0;
  int edge_n   = 0;
  int exp_code_q[$];
  int exp_edge_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks_n++;
    if (got !== exp) begin
      errors_n++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  task automatic push_exp(input int code, input int edge_at);
    exp_code_q.push_back(code);
    exp_edge_q.push_back(edge_at);
  endtask

  // Drive inputs for n cycles; each call consumes one rising edge per cycle.
  task automatic cyc_n(input int n, input logic p, input logic l);
    for (int i = 0; i < n; i++) begin
      btn_if.press = p;
      btn_if.level = l;
      @(posedge clk);
      edge_n++;
      #1;
    end
    btn_if.press = 1'b0;
  endtask

  function automatic int outs();
    return {28'd0, btn_if.short_press, btn_if.long_press, btn_if.double_press, btn_if.busy};
  endfunction

  // Short press: press E0, held E0..E3, released at E4 -> short after E10.
  task automatic do_short();
    int e0;
    e0 = edge_n + 1;
    push_exp(EV_SHORT, e0 + 10);
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(3, 1'b0, 1'b1);
    cyc_n(6, 1'b0, 1'b0);
    check("short_busy_e9", int'(btn_if.busy), 1);
    cyc_n(1, 1'b0, 1'b0);
    check("short_busy_e10", int'(btn_if.busy), 0);
    cyc_n(6, 1'b0, 1'b0);
    check("short_q_empty", exp_code_q.size(), 0);
  endtask

  // Monitor: every event pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    int code;
    code = 0;
    if (btn_if.short_press)       code = EV_SHORT;
    else if (btn_if.long_press)   code = EV_LONG;
    else if (btn_if.double_press) code = EV_DBL;
    if (code != 0) begin
      check("onehot", $countones({btn_if.short_press, btn_if.long_press, btn_if.double_press}), 1);
      if (exp_code_q.size() == 0) begin
        check("unexpected_evt", code, 0);
      end else begin
        check("evt_kind", code, exp_code_q.pop_front());
        check("evt_edge", edge_n, exp_edge_q.pop_front());
      end
    end
  end

  initial begin
    int e0;
    rst_n        = 1'b0;
    btn_if.press = 1'b0;
    btn_if.level = 1'b0;
    #2;
    check("rst_outs", outs(), 0);
    cyc_n(2, 1'b0, 1'b0);
    rst_n = 1'b1;

    // 1. Async reset mid-cycle from HELD, then 10 quiet cycles.
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(2, 1'b0, 1'b1);
    check("pre_rst_busy", int'(btn_if.busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_outs", outs(), 0);
    cyc_n(1, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc_n(1, 1'b0, 1'b0);
      check("post_rst_outs", outs(), 0);
    end

    // 2. Short press.
    do_short();

    // 3. Long press: held 20 cycles -> long after E8, nothing on release.
    e0 = edge_n + 1;
    push_exp(EV_LONG, e0 + 8);
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(19, 1'b0, 1'b1);
    check("long_busy_held", int'(btn_if.busy), 1);
    cyc_n(1, 1'b0, 1'b0);
    check("long_busy_rel", int'(btn_if.busy), 0);
    cyc_n(12, 1'b0, 0);
    check("long_q_empty", exp_code_q.size(), 0);

    // 4. Double press: press E0, release E3, press E5, release E8.
    e0 = edge_n + 1;
    push_exp(EV_DBL, e0 + 8);
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(2, 1'b0, 1'b1);
    cyc_n(2, 1'b0, 1'b0);
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(2, 1'b0, 1'b1);
    cyc_n(1, 1'b0, 1'b0);
    check("dbl_busy_done", int'(btn_if.busy), 0);
    cyc_n(12, 1'b0, 1'b0);
    check("dbl_q_empty", exp_code_q.size(), 0);

    // 5a. Second press on the WAIT2 terminal edge: release E1, press E7, release E9.
    e0 = edge_n + 1;
    push_exp(EV_DBL, e0 + 9);
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(6, 1'b0, 1'b0);
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(1, 1'b0, 1'b1);
    cyc_n(1, 1'b0, 1'b0);
    cyc_n(12, 1'b0, 1'b0);
    check("prio_w2_q_empty", exp_code_q.size(), 0);

    // 5b. Release on the HELD terminal edge E8 -> short after E14, no long.
    e0 = edge_n + 1;
    push_exp(EV_SHORT, e0 + 14);
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(7, 1'b0, 1'b1);
    cyc_n(8, 1'b0, 1'b0);
    check("prio_held_busy", int'(btn_if.busy), 0);
    cyc_n(6, 1'b0, 1'b0);
    check("prio_held_q_empty", exp_code_q.size(), 0);

    // 6. Reset in HELD at cycle 4 aborts silently; a later short press still works.
    cyc_n(1, 1'b1, 1'b1);
    cyc_n(4, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", int'(btn_if.busy), 0);
    cyc_n(1, 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc_n(12, 1'b0, 1'b0);
    check("mid_rst_q_empty", exp_code_q.size(), 0);
    do_short();

    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

  // Watchdog: the stimulus is fixed-length, so this should never be reached.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    errors_n++;
    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $fatal(1, "timeout");
  end
endmodule
